// File: rtl/kmeans_pkg.sv
// Shared constants for the k-means front-end: replay-buffer state encoding and replay direction.
package kmeans_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WRITE = 2'd1;
    localparam logic [1:0] ST_READ  = 2'd2;

    localparam logic MODE_FWD = 1'b0;
    localparam logic MODE_REV = 1'b1;

endpackage

// File: rtl/sp_sram_sync.sv
// Behavioural single-port synchronous RAM with a registered 1-cycle read.
// It can be swapped for the foundry macro without touching the buffer logic.
module sp_sram_sync #(
    parameter int  DATA_W = 16,
    parameter int  DEPTH  = 4096,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= din;
        end
        dout <= mem[addr];
    end

endmodule

// File: rtl/burst_replay_buffer.sv
// Captures one unbroken input burst into SRAM, then replays it forward or reversed on a
// ready/valid output. A 2-entry skid buffer hides the SRAM read latency under backpressure.
module burst_replay_buffer
    import kmeans_pkg::*;
#(
    parameter int  DATA_W = 16,
    parameter int  DEPTH  = 4096,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    input  logic              mode,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              overflow
);

    localparam logic [ADDR_W:0]   LEN_ONE = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] PTR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    logic [1:0]        state;
    logic [ADDR_W:0]   len;
    logic [ADDR_W:0]   len_m1;
    logic [ADDR_W:0]   rd_cnt;
    logic [ADDR_W:0]   out_cnt;
    logic [ADDR_W-1:0] rd_ptr;
    logic              mode_q;
    logic              rd_pending;

    logic [DATA_W-1:0] skid_data [2];
    logic              skid_wr;
    logic              skid_rd;
    logic [1:0]        skid_cnt;

    logic              sram_we;
    logic [ADDR_W-1:0] sram_addr;
    logic [DATA_W-1:0] sram_dout;
    logic              pop;
    logic              issue;
    logic [2:0]        occupancy;

    // len stays at zero while idle, so the first word of a burst naturally lands at address 0.
    always_comb begin
        len_m1    = len - LEN_ONE;
        in_ready  = (state != ST_READ);
        sram_we   = in_valid && (state != ST_READ) && !len[ADDR_W];
        sram_addr = (state == ST_READ) ? rd_ptr : len[ADDR_W-1:0];
        out_valid = (skid_cnt != 2'd0);
        out_data  = out_valid ? skid_data[skid_rd] : '0;
        out_last  = out_valid && (out_cnt == len_m1);
        pop       = out_valid && out_ready;
        occupancy = {1'b0, skid_cnt} + {2'b00, rd_pending};
        // Only issue a read when its data is guaranteed a skid slot one cycle later.
        issue     = (state == ST_READ) && (rd_cnt != len) && ((occupancy < 3'd2) || pop);
    end

    sp_sram_sync #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_sram (
        .clk  (clk),
        .we   (sram_we),
        .addr (sram_addr),
        .din  (in_data),
        .dout (sram_dout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            len        <= '0;
            rd_cnt     <= '0;
            out_cnt    <= '0;
            rd_ptr     <= '0;
            mode_q     <= MODE_FWD;
            overflow   <= 1'b0;
            rd_pending <= 1'b0;
        end else begin
            rd_pending <= issue;
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        state    <= ST_WRITE;
                        len      <= LEN_ONE;
                        mode_q   <= mode;
                        overflow <= 1'b0;
                    end
                end
                ST_WRITE: begin
                    if (in_valid) begin
                        if (len[ADDR_W]) begin
                            overflow <= 1'b1;
                        end else begin
                            len <= len + LEN_ONE;
                        end
                    end else begin
                        state   <= ST_READ;
                        rd_cnt  <= '0;
                        out_cnt <= '0;
                        rd_ptr  <= (mode_q == MODE_REV) ? len_m1[ADDR_W-1:0] : '0;
                    end
                end
                ST_READ: begin
                    if (issue) begin
                        rd_cnt <= rd_cnt + LEN_ONE;
                        // The final issue leaves rd_ptr alone so a reverse replay never steps below 0.
                        if (rd_cnt != len_m1) begin
                            rd_ptr <= (mode_q == MODE_REV) ? rd_ptr - PTR_ONE : rd_ptr + PTR_ONE;
                        end
                    end
                    if (pop) begin
                        out_cnt <= out_cnt + LEN_ONE;
                        if (out_last) begin
                            state <= ST_IDLE;
                            len   <= '0;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            skid_wr  <= 1'b0;
            skid_rd  <= 1'b0;
            skid_cnt <= 2'd0;
        end else begin
            if (rd_pending) begin
                skid_wr <= ~skid_wr;
            end
            if (pop) begin
                skid_rd <= ~skid_rd;
            end
            case ({rd_pending, pop})
                2'b10:   skid_cnt <= skid_cnt + 2'd1;
                2'b01:   skid_cnt <= skid_cnt - 2'd1;
                default: skid_cnt <= skid_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rd_pending) begin
            skid_data[skid_wr] <= sram_dout;
        end
    end

endmodule

// File: tb/tb_burst_replay_buffer.sv
// Directed bench for burst_replay_buffer (DEPTH=8): table of bursts with an expected-replay model,
// plus a hand-written mid-replay reset sequence.
module tb_burst_replay_buffer;

    localparam int DATA_W = 16;
    localparam int DEPTH  = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              mode;
    logic              out_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_last;
    logic              overflow;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        mode;
        int          n;
        logic [15:0] first;
        logic [15:0] step;
        bit          bp;
        bit          poke;
        logic        expOv;
    } vec_t;

    vec_t vecs [9];

    burst_replay_buffer #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .mode      (mode),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Drives one burst, then drains and checks the replay against the model.
    task automatic applyStimulus(input vec_t v);
        logic [15:0] expW [16];
        int          nexp;
        int          k;
        int          cycles;
        int          firstXfer;
        int          lastXfer;
        bit          done;
        bit          prevStall;
        bit          rdy;
        logic [15:0] prevData;
        logic        prevLast;
        logic [15:0] idx;

        nexp = (v.n > DEPTH) ? DEPTH : v.n;
        for (int i = 0; i < nexp; i++) begin
            idx     = 16'(v.mode ? (nexp - 1 - i) : i);
            expW[i] = v.first + v.step * idx;
        end

        for (int i = 0; i < v.n; i++) begin
            @(negedge clk);
            checkOutput("in_ready_write", in_ready, 1);
            in_valid = 1'b1;
            in_data  = v.first + v.step * 16'(i);
            mode     = (i == 0) ? v.mode : ~v.mode;
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;

        @(negedge clk);
        checkOutput("read_first_valid", out_valid, 0);
        checkOutput("read_in_ready", in_ready, 0);

        k = 0; cycles = 0; firstXfer = -1; lastXfer = -1;
        done = 0; prevStall = 0; prevData = '0; prevLast = 1'b0;
        while (!done && cycles < 200) begin
            @(negedge clk);
            cycles++;
            if (prevStall) begin
                checkOutput("stall_valid", out_valid, 1);
                checkOutput("stall_data", out_data, prevData);
                checkOutput("stall_last", out_last, prevLast);
            end
            rdy = v.bp ? 1'($urandom_range(0, 1)) : 1'b1;
            if (out_valid) begin
                if (k < nexp) begin
                    checkOutput("replay_data", out_data, expW[k]);
                    checkOutput("replay_last", out_last, (k == nexp - 1));
                end else begin
                    checkOutput("replay_extra_word", k, nexp - 1);
                end
                if (rdy) begin
                    if (firstXfer < 0) firstXfer = cycles;
                    k++;
                    if (out_last || k > nexp) begin
                        done     = 1;
                        lastXfer = cycles;
                    end
                end
            end else begin
                checkOutput("idle_data_zero", out_data, 0);
                checkOutput("idle_last_zero", out_last, 0);
            end
            prevStall = out_valid && !rdy;
            prevData  = out_data;
            prevLast  = out_last;
            out_ready = rdy;
            if (v.poke && !(out_valid && out_last && rdy)) begin
                in_valid = 1'($urandom_range(0, 1));
                in_data  = 16'hDEAD;
            end else begin
                in_valid = 1'b0;
            end
        end
        checkOutput("replay_done", done, 1);
        checkOutput("replay_count", k, nexp);
        checkOutput("overflow", overflow, v.expOv);
        if (!v.bp && done) begin
            checkOutput("no_bubbles", lastXfer - firstXfer, nexp - 1);
        end
    endtask

    initial begin
        int  k;
        int  cycles;

        vecs[0] = '{1'b0, 4,  16'h1111, 16'h1111, 0, 0, 1'b0};
        vecs[1] = '{1'b1, 4,  16'h1111, 16'h1111, 0, 0, 1'b0};
        vecs[2] = '{1'b0, 8,  16'h0100, 16'h0001, 1, 0, 1'b0};
        vecs[3] = '{1'b0, 10, 16'h0000, 16'h0001, 0, 0, 1'b1};
        vecs[4] = '{1'b0, 2,  16'h00A0, 16'h0001, 0, 0, 1'b0};
        vecs[5] = '{1'b1, 8,  16'h0050, 16'h0003, 1, 1, 1'b0};
        vecs[6] = '{1'b1, 10, 16'h0200, 16'h0001, 1, 0, 1'b1};
        vecs[7] = '{1'b0, 8,  16'h7000, 16'h0011, 0, 1, 1'b0};
        vecs[8] = '{1'b0, 1,  16'hBEEF, 16'h0000, 0, 0, 1'b0};

        rst = 1'b1; in_valid = 1'b0; in_data = '0; mode = 1'b0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset_in_ready", in_ready, 1);
        checkOutput("reset_out_valid", out_valid, 0);
        checkOutput("reset_out_data", out_data, 0);
        checkOutput("reset_out_last", out_last, 0);
        checkOutput("reset_overflow", overflow, 0);
        rst = 1'b0;

        for (int t = 0; t < 9; t++) begin
            $display("[TB] vector %0d: mode=%0d n=%0d", t, vecs[t].mode, vecs[t].n);
            applyStimulus(vecs[t]);
        end

        $display("[TB] mid-replay reset");
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = 16'h0300 + 16'(i);
            mode     = 1'b0;
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        k = 0; cycles = 0;
        while (k < 3 && cycles < 50) begin
            @(negedge clk);
            cycles++;
            if (out_valid) begin
                checkOutput("pre_reset_data", out_data, 16'h0300 + 16'(k));
                k++;
            end
        end
        checkOutput("pre_reset_count", k, 3);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("post_reset_out_valid", out_valid, 0);
        checkOutput("post_reset_in_ready", in_ready, 1);
        checkOutput("post_reset_out_data", out_data, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("post_reset_quiet", out_valid, 0);
        end
        applyStimulus(vecs[0]);

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
